// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and the default counter width.
package pipeline_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REFILL   = 2'd2
    } hz_state_t;

endpackage

// File: rtl/pipeline_loaduse_detect.sv
// Flags an instruction in decode that reads the destination of a load
// still sitting in the ID-EX register.
module pipeline_loaduse_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs1_IFR,
    input  logic [4:0] rs2_IFR,
    input  logic [4:0] rd_IDC,
    input  logic [2:0] dm_rd_ctrl_IDC,
    output logic       load_use_hit
);

    logic is_load;
    logic rd_nonzero;
    logic src_match;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency
    assign is_load      = (dm_rd_ctrl_IDC != 3'd0);
    assign rd_nonzero   = (rd_IDC != 5'd0);
    assign src_match    = (rd_IDC == rs1_IFR) || (rd_IDC == rs2_IFR);
    assign load_use_hit = is_load && rd_nonzero && src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory stalls, branch redirects,
// load-use bubbles and fetch misses, and counts stall / flush cycles.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_IFR,
    input  logic [4:0]       rs2_IFR,
    input  logic [4:0]       rd_IDC,
    input  logic [2:0]       dm_rd_ctrl_IDC,
    input  logic             branch_taken_EX,
    input  logic             dm_req_MEM,
    input  logic             dm_ready,
    input  logic             imem_valid,
    output logic             stall_pc,
    output logic             stall_ifr,
    output logic             stall_idc,
    output logic             stall_exr,
    output logic             stall_memr,
    output logic             flush_ifr,
    output logic             flush_idc,
    output logic             redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state_q;
    hz_state_t state_d;
    logic      load_use_hit;
    logic      mem_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : (v + one);
    endfunction

    pipeline_loaduse_detect u_loaduse (
        .rs1_IFR        (rs1_IFR),
        .rs2_IFR        (rs2_IFR),
        .rd_IDC         (rd_IDC),
        .dm_rd_ctrl_IDC (dm_rd_ctrl_IDC),
        .load_use_hit   (load_use_hit)
    );

    // A pending access keeps the pipe frozen until the memory answers
    assign mem_stall = (dm_req_MEM && !dm_ready) || ((state_q == MEM_WAIT) && !dm_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = RUN;
        stall_pc   = 1'b0;
        stall_ifr  = 1'b0;
        stall_idc  = 1'b0;
        stall_exr  = 1'b0;
        stall_memr = 1'b0;
        flush_ifr  = 1'b0;
        flush_idc  = 1'b0;
        redirect   = 1'b0;

        if (reset) begin
            flush_ifr = 1'b1;
            flush_idc = 1'b1;
        end else if (mem_stall) begin
            stall_pc   = 1'b1;
            stall_ifr  = 1'b1;
            stall_idc  = 1'b1;
            stall_exr  = 1'b1;
            stall_memr = 1'b1;
            state_d    = MEM_WAIT;
        end else if (branch_taken_EX) begin
            redirect  = 1'b1;
            flush_ifr = 1'b1;
            flush_idc = 1'b1;
            state_d   = REFILL;
        end else if (state_q == REFILL) begin
            // The instruction fetched during the redirect cycle is wrong-path
            flush_ifr = 1'b1;
        end else if (load_use_hit) begin
            stall_pc  = 1'b1;
            stall_ifr = 1'b1;
            flush_idc = 1'b1;
        end else if (!imem_valid) begin
            stall_pc  = 1'b1;
            flush_ifr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_idc) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic, with wide and 4-bit counter instances driven in parallel.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_IFR, rs2_IFR, rd_IDC;
    logic [2:0] dm_rd_ctrl_IDC;
    logic       branch_taken_EX, dm_req_MEM, dm_ready, imem_valid;

    logic stall_pc, stall_ifr, stall_idc, stall_exr, stall_memr;
    logic flush_ifr, flush_idc, redirect;
    logic [31:0] stall_cnt, flush_cnt;

    logic s4_pc, s4_ifr, s4_idc, s4_exr, s4_memr, f4_ifr, f4_idc, r4;
    logic [3:0] stall_cnt4, flush_cnt4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] flags;
        longint     sc, fc, sc4, fc4;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: a pending memory access and a pending refill cycle
    bit     m_wait   = 1'b0;
    bit     m_refill = 1'b0;
    longint m_sc = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .rs1_IFR(rs1_IFR), .rs2_IFR(rs2_IFR),
        .rd_IDC(rd_IDC), .dm_rd_ctrl_IDC(dm_rd_ctrl_IDC),
        .branch_taken_EX(branch_taken_EX), .dm_req_MEM(dm_req_MEM),
        .dm_ready(dm_ready), .imem_valid(imem_valid),
        .stall_pc(stall_pc), .stall_ifr(stall_ifr), .stall_idc(stall_idc),
        .stall_exr(stall_exr), .stall_memr(stall_memr),
        .flush_ifr(flush_ifr), .flush_idc(flush_idc), .redirect(redirect),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .rs1_IFR(rs1_IFR), .rs2_IFR(rs2_IFR),
        .rd_IDC(rd_IDC), .dm_rd_ctrl_IDC(dm_rd_ctrl_IDC),
        .branch_taken_EX(branch_taken_EX), .dm_req_MEM(dm_req_MEM),
        .dm_ready(dm_ready), .imem_valid(imem_valid),
        .stall_pc(s4_pc), .stall_ifr(s4_ifr), .stall_idc(s4_idc),
        .stall_exr(s4_exr), .stall_memr(s4_memr),
        .flush_ifr(f4_ifr), .flush_idc(f4_idc), .redirect(r4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, predict the response, queue it, advance.
    task automatic cycle(input bit rst, input bit dreq, input bit drdy, input bit br,
                         input bit iv, input logic [4:0] rdv, input logic [2:0] ctl,
                         input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        bit   stall_event, lu, miss;
        reset = rst; dm_req_MEM = dreq; dm_ready = drdy; branch_taken_EX = br;
        imem_valid = iv; rd_IDC = rdv; dm_rd_ctrl_IDC = ctl; rs1_IFR = r1; rs2_IFR = r2;

        stall_event = !drdy && (dreq || m_wait);
        lu          = (ctl != 0) && (rdv != 0) && (rdv == r1 || rdv == r2);
        miss        = !iv;
        if (rst)              e.flags = 8'b00000_11_0;
        else if (stall_event) e.flags = 8'b11111_00_0;
        else if (br)          e.flags = 8'b00000_11_1;
        else if (m_refill)    e.flags = 8'b00000_10_0;
        else if (lu)          e.flags = 8'b11000_01_0;
        else if (miss)        e.flags = 8'b10000_10_0;
        else                  e.flags = 8'b00000_00_0;
        e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4; e.fc4 = m_fc4;
        exp_q.push_back(e);

        if (rst) begin
            m_wait = 0; m_refill = 0;
            m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
        end else begin
            m_wait   = stall_event;
            m_refill = !stall_event && br;
            if (e.flags[7]) begin
                m_sc  = (m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc;
                m_sc4 = (m_sc4 < 15) ? m_sc4 + 1 : m_sc4;
            end
            if (e.flags[1]) begin
                m_fc  = (m_fc < 64'hFFFF_FFFF) ? m_fc + 1 : m_fc;
                m_fc4 = (m_fc4 < 15) ? m_fc4 + 1 : m_fc4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rst);
        cycle(rst, 0, 1, 0, 1, 5'd0, 3'd0, 5'd1, 5'd2);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("flags", longint'({stall_pc, stall_ifr, stall_idc, stall_exr, stall_memr,
                                     flush_ifr, flush_idc, redirect}), longint'(e.flags));
            check("stall_cnt", longint'(stall_cnt), e.sc);
            check("flush_cnt", longint'(flush_cnt), e.fc);
            check("stall_cnt4", longint'(stall_cnt4), e.sc4);
            check("flush_cnt4", longint'(flush_cnt4), e.fc4);
            check("ifr_excl", longint'(stall_ifr & flush_ifr), 0);
            check("idc_excl", longint'(stall_idc & flush_idc), 0);
        end
    end

    initial begin
        reset = 1; dm_req_MEM = 0; dm_ready = 1; branch_taken_EX = 0; imem_valid = 1;
        rd_IDC = 0; dm_rd_ctrl_IDC = 0; rs1_IFR = 0; rs2_IFR = 0;
        @(posedge clk); #1;

        // Reset state
        idle(1); idle(1); idle(0);

        // Load-use hit, then the same with rd=0
        cycle(0, 0, 1, 0, 1, 5'd5, 3'b010, 5'd5, 5'd9);
        idle(0);
        cycle(0, 0, 1, 0, 1, 5'd0, 3'b010, 5'd0, 5'd9);
        idle(0);

        // Memory wait: three stalled cycles then completion
        repeat (3) cycle(0, 1, 0, 0, 1, 5'd0, 3'd0, 5'd1, 5'd2);
        cycle(0, 1, 1, 0, 1, 5'd0, 3'd0, 5'd1, 5'd2);
        idle(0);

        // Redirect followed by refill
        cycle(0, 0, 1, 1, 1, 5'd0, 3'd0, 5'd1, 5'd2);
        cycle(0, 0, 1, 0, 1, 5'd3, 3'b010, 5'd3, 5'd2);
        idle(0);

        // Branch held across a memory wait
        repeat (2) cycle(0, 1, 0, 1, 1, 5'd0, 3'd0, 5'd1, 5'd2);
        cycle(0, 1, 1, 1, 1, 5'd0, 3'd0, 5'd1, 5'd2);
        idle(0); idle(0);

        // Reset in the middle of a memory wait
        idle(1);
        repeat (6) cycle(0, 0, 1, 0, 1, 5'd7, 3'b001, 5'd2, 5'd7);
        repeat (2) cycle(0, 1, 0, 0, 1, 5'd0, 3'd0, 5'd1, 5'd2);
        cycle(1, 1, 0, 0, 1, 5'd0, 3'd0, 5'd1, 5'd2);
        cycle(0, 0, 0, 0, 1, 5'd0, 3'd0, 5'd1, 5'd2);
        idle(0);

        // Saturation of the narrow counters
        idle(1);
        repeat (20) cycle(0, 0, 1, 0, 0, 5'd0, 3'd0, 5'd1, 5'd2);
        idle(0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(99) < 2),
                  ($urandom_range(99) < 30),
                  ($urandom_range(99) < 60),
                  ($urandom_range(99) < 15),
                  ($urandom_range(99) < 80),
                  5'($urandom_range(3)),
                  ($urandom_range(1) == 1) ? 3'($urandom_range(7)) : 3'd0,
                  5'($urandom_range(3)),
                  5'($urandom_range(3)));
        end

        @(negedge clk);
        #1;
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
